mem_access_unit: RTL and testbench

//  Memory-stage data access engine of the 5-stage ARM pipeline. Sits between the
//  EX/MEM register and the MEM/WB register. Turns LDR/STR/LDRB/STRB in M into a
//  req/ack transaction on the data-memory bus and drives the load result (ReadDataM)

---
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage data access engine: turns LDR/STR/LDRB/STRB in M into a req/ack bus
// transaction and stalls the pipeline until it completes. Optional: ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ValidM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        ByteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        AlignFaultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       lane_r;
  logic             load_r;
  logic             byte_r;
  logic             access;
  logic             misalign;

  function automatic logic [3:0] lane_be(input logic byte_acc, input logic [1:0] k);
    return byte_acc ? (4'b0001 << k) : 4'hF;
  endfunction

  function automatic logic [31:0] store_data(input logic byte_acc, input logic [31:0] wd);
    return byte_acc ? {4{wd[7:0]}} : wd;
  endfunction

  function automatic logic [31:0] load_data(input logic byte_acc, input logic [1:0] k,
                                            input logic [31:0] rd);
    return byte_acc ? {24'h0, rd[{k, 3'b000} +: 8]} : rd;
  endfunction

  assign access  = ValidM & (MemWriteM | MemtoRegM);
  assign cnt_nxt = to_cnt + 1'b1;
  assign StallM  = ((state == IDLE) & access) | (state == WAIT);

`ifdef ALIGN_CHECK_EN
  logic align_flt;
  assign misalign    = ~ByteM & (ALUResultM[1:0] != 2'b00);
  assign AlignFaultM = align_flt;

  // Faulting access skips the bus and goes straight to DONE, so the pulse lands there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) align_flt <= 1'b0;
    else          align_flt <= (state == IDLE) & access & misalign;
  end
`else
  assign misalign    = 1'b0;
  assign AlignFaultM = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      to_cnt    <= '0;
      lane_r    <= 2'b00;
      load_r    <= 1'b0;
      byte_r    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
      ReadDataM <= 32'h0;
      BusErrM   <= 1'b0;
    end else begin
      BusErrM <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (misalign) begin
              ReadDataM <= 32'h0;
              state     <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWriteM;
              mem_addr  <= {ALUResultM[31:2], 2'b00};
              mem_wdata <= store_data(ByteM, WriteDataM);
              mem_be    <= lane_be(ByteM, ALUResultM[1:0]);
              lane_r    <= ALUResultM[1:0];
              load_r    <= ~MemWriteM;
              byte_r    <= ByteM;
              to_cnt    <= '0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (load_r) ReadDataM <= load_data(byte_r, lane_r, mem_rdata);
            state   <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_nxt == CNT_MAX)) begin
            mem_req   <= 1'b0;
            ReadDataM <= 32'h0;
            BusErrM   <= 1'b1;
            state     <= DONE;
          end else begin
            to_cnt <= cnt_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit (default TIMEOUT_CYCLES=16).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ValidM, MemWriteM, MemtoRegM, ByteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, BusErrM, AlignFaultM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  int          n_stall, n_wait;
  logic [31:0] cap_addr, cap_wdata, d_rdata;
  logic [3:0]  cap_be;
  logic        cap_we, d_berr, d_af, d_req, done_ok;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ValidM(ValidM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .ByteM(ByteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .BusErrM(BusErrM), .AlignFaultM(AlignFaultM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one instruction in M; ack on WAIT cycle ack_at (0 = never ack).
  task automatic xfer(input logic we, input logic ld, input logic bt,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int ack_at);
    int cyc;
    @(negedge clk);
    ValidM = 1'b1; MemWriteM = we; MemtoRegM = ld; ByteM = bt;
    ALUResultM = addr; WriteDataM = wd;
    n_stall = 0; n_wait = 0; cyc = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_be = 4'h0; cap_we = 1'b0;
    #1;
    while (StallM && cyc < 100) begin
      n_stall++;
      if (mem_req) begin
        n_wait++;
        if (n_wait == 1) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
        end
        mem_ack   = (n_wait == ack_at);
        mem_rdata = rd;
      end
      @(negedge clk); #1;
      cyc++;
    end
    mem_ack = 1'b0;
    done_ok = (cyc < 100);
    d_rdata = ReadDataM; d_berr = BusErrM; d_af = AlignFaultM; d_req = mem_req;
    ValidM = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0; ByteM = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ValidM = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0; ByteM = 1'b0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'h0, mem_req}, 32'h0);
    chk("rst_stall", {31'h0, StallM},  32'h0);
    chk("rst_rdata", ReadDataM,        32'h0);
    chk("rst_be",    {28'h0, mem_be},  32'h0);
    chk("rst_berr",  {31'h0, BusErrM}, 32'h0);
    reset_n = 1'b1;

    // No access: flag without ValidM, and a stray ack while idle
    @(negedge clk);
    MemtoRegM = 1'b1; mem_ack = 1'b1; #1;
    chk("noacc_stall", {31'h0, StallM}, 32'h0);
    @(negedge clk); #1;
    chk("noacc_req", {31'h0, mem_req}, 32'h0);
    MemtoRegM = 1'b0; mem_ack = 1'b0;

    // LDR 0x100, ack first WAIT cycle
    xfer(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    chk("ldr_done",  {31'h0, done_ok}, 32'h1);
    chk("ldr_stall", n_stall,          32'd2);
    chk("ldr_addr",  cap_addr,         32'h100);
    chk("ldr_be",    {28'h0, cap_be},  32'hF);
    chk("ldr_we",    {31'h0, cap_we},  32'h0);
    chk("ldr_data",  d_rdata,          32'hDEADBEEF);
    chk("ldr_req_done", {31'h0, d_req}, 32'h0);

    // STRB 0x203: lane 3, replicated byte, ReadDataM untouched
    xfer(1'b1, 1'b0, 1'b1, 32'h203, 32'h12345678, 32'h55555555, 1);
    chk("strb_addr",  cap_addr,        32'h200);
    chk("strb_be",    {28'h0, cap_be}, 32'h8);
    chk("strb_wdata", cap_wdata,       32'h78787878);
    chk("strb_we",    {31'h0, cap_we}, 32'h1);
    chk("strb_rdata", d_rdata,         32'hDEADBEEF);

    // Load and store both set -> store, word data unmodified
    xfer(1'b1, 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 32'h66666666, 1);
    chk("both_we",    {31'h0, cap_we}, 32'h1);
    chk("both_wdata", cap_wdata,       32'hCAFEF00D);
    chk("both_rdata", d_rdata,         32'hDEADBEEF);

    // LDRB 0x41, ack on third WAIT cycle
    xfer(1'b0, 1'b1, 1'b1, 32'h41, 32'h0, 32'hAABBCCDD, 3);
    chk("ldrb_stall", n_stall,         32'd4);
    chk("ldrb_be",    {28'h0, cap_be}, 32'h2);
    chk("ldrb_addr",  cap_addr,        32'h40);
    chk("ldrb_data",  d_rdata,         32'h000000CC);

    // LDR with no ack -> timeout after 16 WAIT cycles
    xfer(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h77777777, 0);
    chk("to_done",  {31'h0, done_ok}, 32'h1);
    chk("to_wait",  n_wait,           32'd16);
    chk("to_berr",  {31'h0, d_berr},  32'h1);
    chk("to_req",   {31'h0, d_req},   32'h0);
    chk("to_rdata", d_rdata,          32'h0);
    @(negedge clk); #1;
    chk("to_berr_pulse", {31'h0, BusErrM}, 32'h0);

    // Word access at 0x102
    xfer(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 32'h11111111, 1);
`ifdef ALIGN_CHECK_EN
    chk("mis_wait",  n_wait,          32'd0);
    chk("mis_stall", n_stall,         32'd1);
    chk("mis_af",    {31'h0, d_af},   32'h1);
    chk("mis_rdata", d_rdata,         32'h0);
    @(negedge clk); #1;
    chk("mis_af_pulse", {31'h0, AlignFaultM}, 32'h0);
`else
    chk("mis_wait",  n_wait,          32'd1);
    chk("mis_addr",  cap_addr,        32'h100);
    chk("mis_af",    {31'h0, d_af},   32'h0);
    chk("mis_rdata", d_rdata,         32'h11111111);
`endif

    // Reset asserted while waiting for ack
    @(negedge clk);
    ValidM = 1'b1; MemtoRegM = 1'b1; ALUResultM = 32'h600;
    @(posedge clk); #2;
    chk("rw_req_before", {31'h0, mem_req}, 32'h1);
    reset_n = 1'b0; ValidM = 1'b0; MemtoRegM = 1'b0; #1;
    chk("rw_req_async", {31'h0, mem_req}, 32'h0);
    chk("rw_stall",     {31'h0, StallM},  32'h0);
    chk("rw_rdata",     ReadDataM,        32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk); #1;
    chk("rw_idle_req",   {31'h0, mem_req}, 32'h0);
    chk("rw_idle_stall", {31'h0, StallM},  32'h0);
    xfer(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 32'h0BADF00D, 1);
    chk("rw_after_stall", n_stall, 32'd2);
    chk("rw_after_data",  d_rdata, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
